// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the MEM-stage CPU port
// and a secondary DMA / debug-loader master. The CPU wins by default; a
// starvation counter forces a one-cycle DMA slot, stalling the CPU for that
// cycle. Optional feature macro: DMEM_ARB_LOCK_EN (locked multi-cycle DMA
// ownership, bounded by MAX_LOCK cycles).
module dmem_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_LOCK     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [31:0]       dma_addr,
   input  logic [31:0]       dma_wdata,
   input  logic              dma_lock,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [31:0]       dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam logic [7:0] STARVE_MAX  = 8'(STARVE_LIMIT);
   localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

`ifdef DMEM_ARB_LOCK_EN
   localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);
   localparam bit         LOCK_OK  = (MAX_LOCK > 1);

   typedef enum logic [1:0] {CPU_OWN, DMA_FORCE, DMA_LOCK} state_t;
   logic [7:0] lock_cnt;
`else
   typedef enum logic [1:0] {CPU_OWN, DMA_FORCE} state_t;
`endif

   state_t     state;
   logic [7:0] wait_cnt;
   logic       dma_sel;
   logic       dma_rd_gnt;

   // Byte-address bits outside the word index are decoded downstream.
   logic unused_bits;
`ifdef DMEM_ARB_LOCK_EN
   assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                          dma_addr[31:ADDR_W+2], dma_addr[1:0]};
`else
   assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                          dma_addr[31:ADDR_W+2], dma_addr[1:0], dma_lock};
`endif

   // Decide which master owns the RAM this cycle and whether the CPU must stall.
   always_comb begin
      dma_sel   = 1'b0;
      cpu_stall = 1'b0;
      case (state)
         CPU_OWN: begin
            dma_sel = !cpu_req && dma_req;
         end
         DMA_FORCE: begin
            dma_sel   = dma_req;
            cpu_stall = dma_req && cpu_req;
         end
`ifdef DMEM_ARB_LOCK_EN
         DMA_LOCK: begin
            if (dma_req && dma_lock) begin
               dma_sel   = 1'b1;
               cpu_stall = cpu_req;
            end else begin
               dma_sel = !cpu_req && dma_req;
            end
         end
`endif
         default: begin
            dma_sel = !cpu_req && dma_req;
         end
      endcase
   end

   // RAM port mux; write enable only ever comes from the master that owns the
   // RAM, and is held off while reset is asserted so a dropped access never lands.
   always_comb begin
      dma_gnt    = dma_sel;
      dma_rd_gnt = dma_sel && !dma_we;
      cpu_rdata  = mem_rdata;
      if (dma_sel) begin
         mem_addr  = dma_addr[ADDR_W+1:2];
         mem_wdata = dma_wdata;
         mem_we    = dma_we && !reset;
      end else begin
         mem_addr  = cpu_addr[ADDR_W+1:2];
         mem_wdata = cpu_wdata;
         mem_we    = cpu_req && cpu_we && !reset;
      end
   end

   // Ownership state, starvation counter, lock counter and DMA read-return registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= CPU_OWN;
         wait_cnt   <= 8'd0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= 32'd0;
`ifdef DMEM_ARB_LOCK_EN
         lock_cnt   <= 8'd0;
`endif
      end else begin
         dma_rvalid <= dma_rd_gnt;
         if (dma_rd_gnt) begin
            dma_rdata <= mem_rdata;
         end

         if (dma_gnt || !dma_req) begin
            wait_cnt <= 8'd0;
         end else if (wait_cnt != STARVE_MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         case (state)
            CPU_OWN: begin
               if (dma_req && !dma_gnt && wait_cnt == STARVE_LAST) begin
                  state <= DMA_FORCE;
               end
`ifdef DMEM_ARB_LOCK_EN
               else if (dma_gnt && dma_lock && LOCK_OK) begin
                  state    <= DMA_LOCK;
                  lock_cnt <= 8'd1;
               end
`endif
            end
            DMA_FORCE: begin
               state <= CPU_OWN;
`ifdef DMEM_ARB_LOCK_EN
               if (dma_gnt && dma_lock && LOCK_OK) begin
                  state    <= DMA_LOCK;
                  lock_cnt <= 8'd1;
               end
`endif
            end
`ifdef DMEM_ARB_LOCK_EN
            DMA_LOCK: begin
               if (dma_req && dma_lock && (lock_cnt + 8'd1) < LOCK_MAX) begin
                  lock_cnt <= lock_cnt + 8'd1;
               end else begin
                  state    <= CPU_OWN;
                  lock_cnt <= 8'd0;
               end
            end
`endif
            default: begin
               state <= CPU_OWN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors, a per-cycle control scoreboard
// and a DMA read-return scoreboard, checked by a monitor on the falling edge.
module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
   logic [31:0] dma_addr = 32'd0, dma_wdata = 32'd0;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] ram [32];

   typedef struct packed {
      logic        stall;
      logic        gnt;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
   } ctrl_t;

   ctrl_t       ctrl_q[$];
   logic [31:0] rd_q[$];
   ctrl_t       mon_e;
   logic [31:0] mon_d;
   int          tests_run = 0;
   int          tests_failed = 0;

   dmem_arbiter #(.ADDR_W(5), .STARVE_LIMIT(4), .MAX_LOCK(8)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // RAM model: write on the rising edge, read data available for the next edge.
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = ram[mem_addr];

   // Single comparison point: counts every check and reports any difference.
   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue what the RAM port must show.
   task automatic apply_stimulus(
      input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd, input logic dl,
      input logic es, input logic eg, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
      ctrl_t e;
      @(posedge clock);
      #1;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
      e.stall = es; e.gnt = eg; e.we = ew; e.addr = ea; e.wdata = ed;
      ctrl_q.push_back(e);
   endtask

   // Queue the data a granted DMA read must return on the following cycle.
   task automatic expect_read(input logic [31:0] d);
      rd_q.push_back(d);
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
   endtask

   // Monitor: compare the RAM-side controls every driven cycle, and each read return as it appears.
   always @(negedge clock) begin
      if (!reset) begin
         if (ctrl_q.size() > 0) begin
            mon_e = ctrl_q.pop_front();
            check_output("cpu_stall", {31'd0, cpu_stall}, {31'd0, mon_e.stall});
            check_output("dma_gnt", {31'd0, dma_gnt}, {31'd0, mon_e.gnt});
            check_output("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
            check_output("mem_addr", {27'd0, mem_addr}, {27'd0, mon_e.addr});
            check_output("mem_wdata", mem_wdata, mon_e.wdata);
         end
         if (dma_rvalid) begin
            if (rd_q.size() == 0) begin
               check_output("dma_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
               mon_d = rd_q.pop_front();
               check_output("dma_rdata", dma_rdata, mon_d);
            end
         end
      end
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   // Directed test sequence.
   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 32'd0;

      // Reset values
      #3;
      check_output("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      check_output("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_output("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
      check_output("rst_dma_rdata", dma_rdata, 32'd0);
      @(negedge clock);
      #2 reset = 1'b0;

      // CPU-only store to word 4
      apply_stimulus(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,0, 0,0,1,5'd4,32'hDEADBEEF);
      // DMA read of word 4 while CPU idle
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h10,32'h0,0, 0,1,0,5'd4,32'h0);
      expect_read(32'hDEADBEEF);
      // DMA write to word 8
      apply_stimulus(0,0,32'h0,32'h0, 1,1,32'h20,32'h12345678,0, 0,1,1,5'd8,32'h12345678);
      // Back-to-back DMA reads
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h20,32'h0,0, 0,1,0,5'd8,32'h0);
      expect_read(32'h12345678);
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h10,32'h0,0, 0,1,0,5'd4,32'h0);
      expect_read(32'hDEADBEEF);
      // Nobody requesting: RAM port follows CPU inputs, no write
      apply_stimulus(0,1,32'h44,32'h0000AAAA, 0,0,32'h0,32'h0,0, 0,0,0,5'h11,32'h0000AAAA);

      // Starvation: CPU stores against a held DMA write; every fifth cycle is forced
      for (int i = 1; i <= 10; i++) begin
         if (i == 5 || i == 10)
            apply_stimulus(1,1,32'h40 + 32'(4*i),32'(i), 1,1,32'h30,32'hCAFE0001,0,
                           1,1,1,5'd12,32'hCAFE0001);
         else
            apply_stimulus(1,1,32'h40 + 32'(4*i),32'(i), 1,1,32'h30,32'hCAFE0001,0,
                           0,0,1,5'(5'h10 + i),32'(i));
      end
      apply_stimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,0, 0,0,0,5'd0,32'h0);

      // DMA drops its request just before the forced slot: no grant, no stall
      for (int i = 1; i <= 4; i++)
         apply_stimulus(1,0,32'h0,32'h0, 1,1,32'h30,32'hCAFE0001,0, 0,0,0,5'd0,32'h0);
      apply_stimulus(1,0,32'h0,32'h0, 0,1,32'h30,32'hCAFE0001,0, 0,0,0,5'd0,32'h0);
      for (int i = 1; i <= 4; i++)
         apply_stimulus(1,0,32'h0,32'h0, 1,1,32'h30,32'hCAFE0001,0, 0,0,0,5'd0,32'h0);
      apply_stimulus(1,0,32'h0,32'h0, 1,1,32'h30,32'hCAFE0001,0, 1,1,1,5'd12,32'hCAFE0001);
      apply_stimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,0, 0,0,0,5'd0,32'h0);

      // Reset asserted in the middle of a forced DMA write
      for (int i = 1; i <= 4; i++)
         apply_stimulus(1,0,32'h0,32'h0, 1,1,32'h34,32'hBAD0BAD0,0, 0,0,0,5'd0,32'h0);
      @(posedge clock);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7C; cpu_wdata = 32'h00005555;
      #2 reset = 1'b1;
      #1;
      check_output("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      check_output("midrst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      check_output("midrst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      check_output("midrst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
      check_output("midrst_dma_rdata", dma_rdata, 32'd0);
      @(posedge clock);
      #1;
      check_output("midrst_hold_mem_we", {31'd0, mem_we}, 32'd0);
      idle_inputs();
      #2 reset = 1'b0;

      // After release: full starvation window again, forced read of word 4
      for (int i = 1; i <= 4; i++)
         apply_stimulus(1,0,32'h0,32'h0, 1,0,32'h10,32'h0,0, 0,0,0,5'd0,32'h0);
      apply_stimulus(1,0,32'h0,32'h0, 1,0,32'h10,32'h0,0, 1,1,0,5'd4,32'h0);
      expect_read(32'hDEADBEEF);
      apply_stimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,0, 0,0,0,5'd0,32'h0);

`ifdef DMEM_ARB_LOCK_EN
      // Locked DMA reads: forced entry, then eight consecutive grants in total
      for (int i = 1; i <= 17; i++) begin
         if ((i >= 5 && i <= 12) || i == 17) begin
            apply_stimulus(1,0,32'h0,32'h0, 1,0,32'h10,32'h0,1, 1,1,0,5'd4,32'h0);
            expect_read(32'hDEADBEEF);
         end else begin
            apply_stimulus(1,0,32'h0,32'h0, 1,0,32'h10,32'h0,1, 0,0,0,5'd0,32'h0);
         end
      end
      apply_stimulus(1,0,32'h0,32'h0, 0,0,32'h10,32'h0,1, 0,0,0,5'd0,32'h0);
      apply_stimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,0, 0,0,0,5'd0,32'h0);
`endif

      // Read back RAM to confirm which writes landed
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h54,32'h0,0, 0,1,0,5'h15,32'h0);
      expect_read(32'h0);
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h50,32'h0,0, 0,1,0,5'h14,32'h0);
      expect_read(32'h4);
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h30,32'h0,0, 0,1,0,5'd12,32'h0);
      expect_read(32'hCAFE0001);
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h34,32'h0,0, 0,1,0,5'd13,32'h0);
      expect_read(32'h0);
      apply_stimulus(0,0,32'h0,32'h0, 1,0,32'h7C,32'h0,0, 0,1,0,5'h1F,32'h0);
      expect_read(32'h0);
      apply_stimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,0, 0,0,0,5'd0,32'h0);

      repeat (3) @(posedge clock);
      #1;
      check_output("ctrl_q_drained", 32'(ctrl_q.size()), 32'd0);
      check_output("rd_q_drained", 32'(rd_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
